// File: rtl/fp32_accumulator_pkg.sv
// Shared FP32 field layout, exponent constants and the accumulator state
// encoding used by fp32_accumulator and its floating_adder.
package fp32_accumulator_pkg;

    localparam int FP_W        = 32;
    localparam int FP_SIGN_BIT = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_MAN_MSB  = 22;
    localparam int FP_MAN_LSB  = 0;
    localparam int FP_EXP_W    = 8;
    localparam int FP_MAN_W    = 23;

    localparam logic [FP_EXP_W-1:0] FP_EXP_ONES = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/fp32_accumulator_adder.sv
// floating_adder: purely combinational FP32 adder.
// - exponent 0 operands are treated as zero (no denormals)
// - exponent 255 operands are handled as ordinary numbers (no NaN/Inf)
// - round toward zero (truncation); exact cancellation yields +0
// - result sign follows the larger-magnitude operand
// - results whose exponent underflows flush to +0; exponent overflow
//   clamps the exponent field to 8'hFF
import fp32_accumulator_pkg::*;

module floating_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] o
);

    // 24-bit significand followed by 26 guard bits; shifted-out bits of the
    // smaller operand collapse into a sticky LSB so truncation stays exact.
    localparam int ALN_W = 50;

    logic [7:0]        ea, eb;
    logic              a_zero, b_zero, a_big;
    logic [7:0]        el, es;
    logic [23:0]       ml, ms;
    logic              sl, ss;
    logic [7:0]        diff;
    logic [ALN_W-1:0]  big_al, sml_al, sml_sh;
    logic              sticky;
    logic [ALN_W:0]    mag;
    logic [5:0]        lead;
    logic [ALN_W-1:0]  norm;
    logic signed [9:0] exp_n;
    logic [22:0]       man;

    // Number of leading zeros in a non-zero aligned magnitude.
    function automatic logic [5:0] lead_zeros(input logic [ALN_W-1:0] v);
        logic [5:0] n;
        logic       found;
        n     = 6'd0;
        found = 1'b0;
        for (int i = ALN_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                found = 1'b1;
            end else if (!found) begin
                n = n + 6'd1;
            end
        end
        return n;
    endfunction

    // Pack a normalised result, flushing underflow to +0 and clamping the
    // exponent field at 8'hFF on overflow.
    function automatic logic [31:0] pack_fp(input logic s,
                                            input logic signed [9:0] e,
                                            input logic [22:0] m);
        if (e <= 10'sd0) begin
            return 32'd0;
        end else if (e > 10'sd255) begin
            return {s, FP_EXP_ONES, m};
        end else begin
            return {s, e[7:0], m};
        end
    endfunction

    // Align, add/subtract, normalise and pack.
    always_comb begin
        ea     = a[FP_EXP_MSB:FP_EXP_LSB];
        eb     = b[FP_EXP_MSB:FP_EXP_LSB];
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        a_big  = (a[FP_EXP_MSB:0] >= b[FP_EXP_MSB:0]);

        if (a_big) begin
            el = ea; es = eb;
            ml = {1'b1, a[FP_MAN_MSB:FP_MAN_LSB]};
            ms = {1'b1, b[FP_MAN_MSB:FP_MAN_LSB]};
            sl = a[FP_SIGN_BIT]; ss = b[FP_SIGN_BIT];
        end else begin
            el = eb; es = ea;
            ml = {1'b1, b[FP_MAN_MSB:FP_MAN_LSB]};
            ms = {1'b1, a[FP_MAN_MSB:FP_MAN_LSB]};
            sl = b[FP_SIGN_BIT]; ss = a[FP_SIGN_BIT];
        end

        diff   = el - es;
        big_al = {ml, 26'd0};
        sml_al = {ms, 26'd0};
        if (diff >= 8'd50) begin
            sml_sh = '0;
            sticky = 1'b1;
        end else begin
            sml_sh = sml_al >> diff;
            sticky = ((sml_sh << diff) != sml_al);
        end
        sml_sh = sml_sh | {{(ALN_W-1){1'b0}}, sticky};

        if (sl == ss) begin
            mag = {1'b0, big_al} + {1'b0, sml_sh};
        end else begin
            mag = {1'b0, big_al} - {1'b0, sml_sh};
        end

        lead  = 6'd0;
        norm  = '0;
        exp_n = 10'sd0;
        man   = 23'd0;
        if (mag[ALN_W]) begin
            exp_n = $signed({2'b00, el}) + 10'sd1;
            man   = 23'(mag >> 27);
        end else begin
            lead  = lead_zeros(mag[ALN_W-1:0]);
            norm  = mag[ALN_W-1:0] << lead;
            exp_n = $signed({2'b00, el}) - $signed({4'b0000, lead});
            man   = 23'(norm >> 26);
        end

        if (a_zero && b_zero) begin
            o = 32'd0;
        end else if (a_zero) begin
            o = b;
        end else if (b_zero) begin
            o = a;
        end else if (mag == '0) begin
            o = 32'd0;
        end else begin
            o = pack_fp(sl, exp_n, man);
        end
    end

endmodule

// File: rtl/fp32_accumulator.sv
// fp32_accumulator: sums a valid/ready stream of FP32 values terminated by
// in_last and presents the sum and element count on an output stream.
// Optional macro FPACC_OVF_DETECT_EN adds a sticky out_ovf flag that is set
// whenever an accumulator update produces exponent field 8'hFF.
import fp32_accumulator_pkg::*;

module fp32_accumulator #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
`ifdef FPACC_OVF_DETECT_EN
    output logic             out_ovf,
`endif
    output logic [CNT_W-1:0] out_count
);

    acc_state_e       state, state_nxt;
    logic [31:0]      acc;
    logic [31:0]      sum;
    logic [CNT_W-1:0] cnt;
    logic             in_fire;

    // Saturating element-count increment.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (&c) begin
            return c;
        end else begin
            return c + CNT_W'(1);
        end
    endfunction

    floating_adder u_add (
        .a (acc),
        .b (in_data),
        .o (sum)
    );

    assign in_fire   = in_valid & in_ready;
    assign out_data  = acc;
    assign out_count = cnt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = in_last ? OUT : ACC;
                end
            end
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && in_last) begin
                    state_nxt = OUT;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Accumulator and counter: first beat loads directly, later beats add.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 32'd0;
            cnt <= '0;
        end else if (in_fire) begin
            if (state == IDLE) begin
                acc <= in_data;
                cnt <= CNT_W'(1);
            end else begin
                acc <= sum;
                cnt <= sat_inc(cnt);
            end
        end
    end

`ifdef FPACC_OVF_DETECT_EN
    logic ovf;

    // Sticky overflow flag, restarted by each vector's first beat and
    // cleared when the result is delivered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (out_valid && out_ready) begin
            ovf <= 1'b0;
        end else if (in_fire) begin
            if (state == IDLE) begin
                ovf <= (in_data[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_ONES);
            end else begin
                ovf <= ovf | (sum[FP_EXP_MSB:FP_EXP_LSB] == FP_EXP_ONES);
            end
        end
    end

    assign out_ovf = ovf;
`endif

endmodule

// File: tb/tb_fp32_accumulator.sv
// Directed testbench for fp32_accumulator (counter width reduced to 3 bits
// so saturation is reachable in a few beats).
module tb_fp32_accumulator;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [31:0]   in_data = 32'd0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   out_data;
    logic [CW-1:0] out_count;
`ifdef FPACC_OVF_DETECT_EN
    logic          out_ovf;
`endif

    int checks = 0;
    int errors = 0;

    fp32_accumulator #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef FPACC_OVF_DETECT_EN
        .out_ovf   (out_ovf),
`endif
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present one beat and hold it until accepted; returns #1 after the edge.
    task automatic send_beat(input logic [31:0] d, input logic l);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("beat_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 32'hDEADBEEF;
    endtask

    // Let the pending result be delivered and confirm return to IDLE.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_data",  out_data,           32'd0);
        check("rst_out_count", 32'(out_count),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1 + 2 + 3 = 6
        send_beat(32'h3F800000, 1'b0);
        send_beat(32'h40000000, 1'b0);
        check("sum3_mid_valid", {31'd0, out_valid}, 32'd0);
        send_beat(32'h40400000, 1'b1);
        check("sum3_valid", {31'd0, out_valid}, 32'd1);
        check("sum3_data",  out_data,           32'h40C00000);
        check("sum3_count", 32'(out_count),     32'd3);
        drain("sum3");

        // Exact cancellation gives +0
        send_beat(32'h3FC00000, 1'b0);
        send_beat(32'hBFC00000, 1'b1);
        check("cancel_data",  out_data,       32'h00000000);
        check("cancel_count", 32'(out_count), 32'd2);
        drain("cancel");

        // Single-element vector
        send_beat(32'hC1200000, 1'b1);
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_data",  out_data,           32'hC1200000);
        check("single_count", 32'(out_count),     32'd1);
        drain("single");

        // 1.0 + (-2.0) = -1.0: sign from larger magnitude
        send_beat(32'h3F800000, 1'b0);
        send_beat(32'hC0000000, 1'b1);
        check("sign_data", out_data, 32'hBF800000);
        drain("sign");

        // Truncation: 1.0 + 0.75 ulp stays 1.0
        send_beat(32'h3F800000, 1'b0);
        send_beat(32'h33C00000, 1'b1);
        check("trunc_add", out_data, 32'h3F800000);
        drain("trunc_add");

        // Truncation toward zero on subtraction: 1.0 - 1.5*2^-24
        send_beat(32'h3F800000, 1'b0);
        send_beat(32'hB3C00000, 1'b1);
        check("trunc_sub", out_data, 32'h3F7FFFFE);
        drain("trunc_sub");

        // Exponent-0 operand treated as zero
        send_beat(32'h3F800000, 1'b0);
        send_beat(32'h00000001, 1'b1);
        check("denorm_zero", out_data, 32'h3F800000);
        drain("denorm");

        // Backpressure: 5.0 + 0.5 = 5.5 held while out_ready=0
        out_ready = 1'b0;
        send_beat(32'h40A00000, 1'b0);
        send_beat(32'h3F000000, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_ready", {31'd0, in_ready},  32'd0);
            check("hold_data",  out_data,           32'h40B00000);
            check("hold_count", 32'(out_count),     32'd2);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain("hold");

        // Counter saturates at 2^CW-1; nine 1.0 beats sum to 9.0
        for (int i = 0; i < 8; i++) send_beat(32'h3F800000, 1'b0);
        send_beat(32'h3F800000, 1'b1);
        check("sat_data",  out_data,       32'h41100000);
        check("sat_count", 32'(out_count), 32'd7);
        drain("sat");

        // Reset mid-vector discards the partial sum
        send_beat(32'h40000000, 1'b0);
        send_beat(32'h40000000, 1'b0);
        rst_n = 1'b0;
        #3;
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_data",  out_data,           32'd0);
        check("midrst_count", 32'(out_count),     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_valid", {31'd0, out_valid}, 32'd0);
        check("postrst_ready", {31'd0, in_ready},  32'd1);
        send_beat(32'h40000000, 1'b1);
        check("postrst_data",  out_data,       32'h40000000);
        check("postrst_count", 32'(out_count), 32'd1);
        drain("postrst");

`ifdef FPACC_OVF_DETECT_EN
        // Overflow flag sets on exponent 8'hFF and clears for the next vector
        send_beat(32'h7F7FFFFF, 1'b0);
        send_beat(32'h7F7FFFFF, 1'b1);
        check("ovf_set",  {31'd0, out_ovf}, 32'd1);
        check("ovf_data", out_data,         32'h7FFFFFFF);
        drain("ovf");
        send_beat(32'h3F800000, 1'b1);
        check("ovf_clear", {31'd0, out_ovf}, 32'd0);
        drain("ovf_clean");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp32_accumulator.md
FP32_ACCUMULATOR -- requirements
Module: fp32_accumulator

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16: the width of the element counter.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have the following input stream ports:
- in_valid, input, 1 bit: the input beat is valid.
- in_ready, output, 1 bit: the block can accept a beat.
- in_data, input, 32 bits: IEEE-754 single-precision operand.
- in_last, input, 1 bit: the final element of the current vector.
REQ-005 The block SHALL have the following output stream ports:
- out_valid, output, 1 bit: the result is valid.
- out_ready, input, 1 bit: the consumer accepts the result.
- out_data, output, 32 bits: FP32 sum of the vector.
- out_count, output, CNT_W bits: number of elements summed.

Function
REQ-006 A beat SHALL be accepted on any rising edge where in_valid and in_ready are both 1; a result SHALL be delivered on any rising edge where out_valid and out_ready are both 1.
REQ-007 The state machine SHALL have three states, IDLE, ACC and OUT, with these transitions:
- IDLE to ACC: a beat is accepted with in_last=0.
- IDLE to OUT: a beat is accepted with in_last=1.
- ACC to OUT: a beat is accepted with in_last=1.
- OUT to IDLE: the result is delivered.
- In all other cases the state SHALL hold.
REQ-008 in_ready SHALL be 1 in IDLE and ACC and 0 in OUT, so input acceptance and output delivery never occur in the same cycle.
REQ-009 out_valid SHALL be 1 only in OUT.
REQ-010 The first beat accepted in IDLE SHALL load the accumulator with in_data unchanged, with no addition against zero.
REQ-011 Each beat accepted in ACC SHALL update the accumulator to fp_add(acc, in_data) in the same cycle.
REQ-012 fp_add SHALL use round-by-truncation, produce +0 for an exact cancellation, and return the sign of the larger-magnitude operand.
REQ-013 Latency: if the in_last beat is accepted at edge t, out_valid SHALL be 1 after edge t, with out_data equal to the final sum.
REQ-014 out_data and out_count SHALL remain stable while out_valid=1 and out_ready=0.
REQ-015 The counter SHALL be set to 1 on the first beat and incremented on each later accepted beat, saturating at 2^CNT_W-1 with no wrap.
REQ-016 A single-element vector (in_last=1 on the first beat) SHALL give out_data=in_data and out_count=1.
REQ-017 in_data SHALL be ignored when no beat is accepted; in_last SHALL be ignored unless in_valid=1.
REQ-018 Inputs with exponent 0 SHALL be treated as zero by the adder (no denormal support), and inputs with exponent 255 SHALL be added arithmetically with no NaN/Inf special-casing.
REQ-019 The adder path SHALL be combinational between the accumulator register and its D input, with no internal pipelining.

Reset
REQ-020 While rst_n=0 the block SHALL hold state IDLE, accumulator 0, counter 0, out_valid=0, out_data=0, out_count=0, and in_ready=1 after deassertion.
REQ-021 Reset asserted mid-vector or in OUT SHALL discard the partial sum or pending result immediately, with no output delivered.

Configuration
REQ-022 When the macro FPACC_OVF_DETECT_EN is defined, the block SHALL add an output out_ovf, 1 bit, set sticky within a vector whenever an accumulator update yields exponent field 8'hFF.
REQ-023 When FPACC_OVF_DETECT_EN is defined, out_ovf SHALL be valid with out_data, held with it, cleared on delivery and cleared by reset.
REQ-024 When FPACC_OVF_DETECT_EN is undefined, the out_ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-025 A shared package SHALL hold the FP32 field widths and positions (sign bit 31, exponent 30:23, mantissa 22:0), the exponent constant 8'hFF, and the state encoding type for IDLE, ACC and OUT.
REQ-026 The FP32 addition SHALL be a single sub-module, floating_adder (ports a, b, o, purely combinational), instantiated once with a=acc and b=in_data.

Verification
REQ-027 The bench SHALL feed 0x3F800000, 0x40000000 and 0x40400000 (last on the third), with out_ready=1, and check out_data=0x40C00000, out_count=3, and out_valid one cycle after the last beat.
REQ-028 The bench SHALL feed 0x3FC00000 then 0xBFC00000 (last) and check out_data=0x00000000 and out_count=2.
REQ-029 The bench SHALL feed the single beat 0xC1200000 with in_last=1 and check out_data=0xC1200000 and out_count=1.
REQ-030 The bench SHALL hold out_ready=0 for 5 cycles with in_valid=1 and check that out_data and out_count stay stable, in_ready=0, and no beat is consumed; on out_ready=1 it SHALL check delivery and return to IDLE.
REQ-031 The bench SHALL drop rst_n after 2 beats of a 4-beat vector and check out_valid=0 and in_ready=1 after release, and that a fresh vector 0x40000000 (last) gives 0x40000000 with count 1.
REQ-032 With FPACC_OVF_DETECT_EN defined, the bench SHALL feed 0x7F7FFFFF twice (last on the second) and check out_ovf=1, then check the next clean vector gives out_ovf=0.
